// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared by the ALU and the muldiv sequencer, plus sequencer encodings
package alu_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;

    localparam logic [1:0] MD_MUL   = 2'd0;
    localparam logic [1:0] MD_MULHU = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_REMU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MUL/MULHU/DIVU/REMU sequencer driving the shared ALU
// Ports: clk/rst_n (async active-low); start/op/op_a/op_b request; kill aborts;
//        busy/done/result status; alu_signal/alu_a/alu_b to the ALU, alu_out back.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      alu_signal,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out
);
    md_state_e       state, state_nx;
    logic [1:0]      op_q;
    logic [XLEN-1:0] b_q, hi, lo, hi_nx, lo_nx, r;
    logic [CNT_W-1:0] cnt;
    logic            accept, div0, last, carry, take;

    // start is only honoured in IDLE, and a simultaneous kill wins
    assign accept = (state == IDLE) && start && !kill;
    assign div0   = op[1] && (op_b == '0);
    assign last   = cnt == CNT_W'(XLEN - 1);
    assign busy   = state == CALC;
    assign done   = state == DONE;

    // b_q holds the multiplicand for multiplies and the divisor for divides
    assign r     = {hi[XLEN-2:0], lo[XLEN-1]};
    assign carry = alu_out < hi;
    assign take  = hi[XLEN-1] | (r >= b_q);
    assign hi_nx = op_q[1] ? (take ? alu_out : r) : {carry, alu_out[XLEN-1:1]};
    assign lo_nx = op_q[1] ? {lo[XLEN-2:0], take} : {alu_out[0], lo[XLEN-1:1]};

    always_comb begin
        alu_signal = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        if (state == CALC) begin
            alu_signal = op_q[1] ? ALU_SUB : ALU_ADD;
            alu_a      = op_q[1] ? r : hi;
            alu_b      = (op_q[1] || lo[0]) ? b_q : '0;
        end
    end

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE)
            state_nx = accept ? (div0 ? DONE : CALC) : IDLE;
        else if (state == CALC)
            state_nx = kill ? IDLE : (last ? DONE : CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= MD_MUL;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op;
                b_q  <= op[1] ? op_b : op_a;
                hi   <= '0;
                lo   <= op[1] ? op_a : op_b;
                cnt  <= '0;
                if (div0)
                    result <= (op == MD_DIVU) ? '1 : op_a;
            end else if (state == CALC && !kill) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= cnt + 1'b1;
                // odd opcodes (MULHU, REMU) return the upper register
                if (last)
                    result <= op_q[0] ? hi_nx : lo_nx;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven scoreboard bench for muldiv_seq with an ALU model
module tb_muldiv_seq;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [4:0]  alu_signal;

    int n_chk = 0, n_fail = 0, done_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;
    vec_t v[13];

    always #5 clk = ~clk;

    assign alu_out = (alu_signal == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .kill(kill), .busy(busy), .done(done), .result(result),
        .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0)
                check("unexpected_done", 32'(done), 32'd0);
            else
                check("result", result, sb.pop_front());
        end
    end

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit ignored_start);
        int cyc, bad;
        logic [4:0] sig;
        sig = o[1] ? ALU_SUB : ALU_ADD;
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        sb.push_back(exp);
        last_exp = exp;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bad = 0;
        while (!done && cyc < 60) begin
            if (!busy || alu_signal !== sig) bad++;
            if (ignored_start && cyc == 5) begin
                op = MD_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", 32'(cyc), 32'(lat));
        check("calc_busy_and_alu_op", 32'(bad), 32'd0);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        v[0]  = '{MD_MUL,   32'd7,        32'd6,        32'd42,       33};
        v[1]  = '{MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        v[2]  = '{MD_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        v[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd14,       33};
        v[4]  = '{MD_REMU,  32'd100,      32'd7,        32'd2,        33};
        v[5]  = '{MD_DIVU,  32'h80000000, 32'd1,        32'h80000000, 33};
        v[6]  = '{MD_REMU,  32'd5,        32'd9,        32'd5,        33};
        v[7]  = '{MD_DIVU,  32'd123,      32'd0,        32'hFFFFFFFF, 1};
        v[8]  = '{MD_REMU,  32'd123,      32'd0,        32'd123,      1};
        v[9]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd3,        32'h55555555, 33};
        v[10] = '{MD_REMU,  32'hFFFFFFFF, 32'd10,       32'd5,        33};
        v[11] = '{MD_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 33};
        v[12] = '{MD_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 33};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_alu_signal", 32'(alu_signal), 32'(ALU_ADD));
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run(v[i].op, v[i].a, v[i].b, v[i].exp, v[i].lat, 1'b0);

        d0 = done_cnt;
        run(MD_MUL, 32'd7, 32'd6, 32'd42, 33, 1'b1);
        check("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        @(negedge clk);
        op = MD_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_alu_signal", 32'(alu_signal), 32'(ALU_ADD));
        check("kill_result_held", result, last_exp);
        repeat (40) @(negedge clk);
        check("kill_no_done", 32'(done_cnt - d0), 32'd0);

        d0 = done_cnt;
        @(negedge clk);
        op = MD_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_alu_signal", 32'(alu_signal), 32'(ALU_ADD));
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);

        run(MD_REMU, 32'd1000, 32'd33, 32'd10, 33, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
